// File: rtl/window_line_buffer.sv
// Streaming line buffer: keeps P_KERNEL rows of a raster stream and emits one
// P_KERNEL x P_KERNEL neighbourhood per pixel with zero or replicate border fill.
module window_line_buffer #(
  parameter int unsigned P_COLUMNS     = 640,
  parameter int unsigned P_ROWS        = 480,
  parameter int unsigned P_PIXEL_DEPTH = 8,
  parameter int unsigned P_KERNEL      = 3
) (
  input  logic                                             I_CLK,
  input  logic                                             I_RESET,
  input  logic [P_PIXEL_DEPTH-1:0]                         I_PIXEL,
  input  logic                                             I_VALID,
  output logic                                             O_READY,
  input  logic                                             I_BORDER_MODE,
  output logic [P_KERNEL*P_KERNEL*P_PIXEL_DEPTH-1:0]       O_WINDOW,
  output logic                                             O_VALID,
  output logic [$clog2(P_COLUMNS)-1:0]                     O_CENTER_COLUMN,
  output logic [$clog2(P_ROWS)-1:0]                        O_CENTER_ROW,
  output logic                                             O_FRAME_DONE
);

  localparam int LP_K    = int'(P_KERNEL);
  localparam int LP_H    = (LP_K - 1) / 2;
  localparam int LP_KK   = LP_K * LP_K;
  localparam int LP_D    = int'(P_PIXEL_DEPTH);
  localparam int LP_ROWS = int'(P_ROWS);
  localparam int LP_COLS = int'(P_COLUMNS);
  localparam int unsigned CW = $clog2(P_COLUMNS);
  localparam int unsigned RW = $clog2(P_ROWS);
  localparam int unsigned SW = $clog2(P_KERNEL);

  typedef enum logic [1:0] {StLoad, StEmit, StFlush} state_e;

  state_e r_state, w_state_next;

  logic [P_PIXEL_DEPTH-1:0] r_mem [P_KERNEL][P_COLUMNS];

  logic [CW-1:0] r_in_col, r_sweep_col;
  logic [RW-1:0] r_in_row, r_emit_row;
  logic [SW-1:0] r_in_slot, r_emit_slot;
  logic          r_mode;
  logic          r_ready;

  logic [P_KERNEL*P_KERNEL*P_PIXEL_DEPTH-1:0] r_window;
  logic                                       r_valid;
  logic [CW-1:0]                              r_center_col;
  logic [RW-1:0]                              r_center_row;
  logic                                       r_frame_done;

  logic w_accept, w_in_col_last, w_load_done;
  logic w_sweeping, w_sweep_last, w_frame_last;
  logic [P_KERNEL*P_KERNEL*P_PIXEL_DEPTH-1:0] w_window;

  assign w_accept      = r_ready & I_VALID;
  assign w_in_col_last = (r_in_col == CW'(P_COLUMNS - 1));
  assign w_load_done   = w_accept & w_in_col_last &
                         (int'(r_in_row) == int'(r_emit_row) + LP_H);
  assign w_sweeping    = (r_state != StLoad);
  assign w_sweep_last  = w_sweeping & (r_sweep_col == CW'(P_COLUMNS - 1));
  assign w_frame_last  = w_sweep_last & (r_emit_row == RW'(P_ROWS - 1));

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_state <= StLoad;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StLoad: begin
        if (w_load_done) w_state_next = StEmit;
      end
      StEmit: begin
        // Rows whose lower neighbours are still to arrive go back to loading.
        if (w_sweep_last) begin
          w_state_next = (int'(r_emit_row) + 1 <= LP_ROWS - 1 - LP_H) ? StLoad : StFlush;
        end
      end
      StFlush: begin
        if (w_frame_last) w_state_next = StLoad;
      end
      default: w_state_next = StLoad;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_in_col    <= '0;
      r_in_row    <= '0;
      r_in_slot   <= '0;
      r_sweep_col <= '0;
      r_emit_row  <= '0;
      r_emit_slot <= '0;
      r_mode      <= 1'b0;
    end else if (w_frame_last) begin
      r_in_col    <= '0;
      r_in_row    <= '0;
      r_in_slot   <= '0;
      r_sweep_col <= '0;
      r_emit_row  <= '0;
      r_emit_slot <= '0;
    end else begin
      if (w_accept) begin
        if (r_in_col == '0 && r_in_row == '0) r_mode <= I_BORDER_MODE;
        if (w_in_col_last) begin
          r_in_col  <= '0;
          r_in_row  <= r_in_row + 1'b1;
          r_in_slot <= (r_in_slot == SW'(P_KERNEL - 1)) ? '0 : r_in_slot + 1'b1;
        end else begin
          r_in_col <= r_in_col + 1'b1;
        end
      end
      if (w_sweeping) begin
        if (w_sweep_last) begin
          r_sweep_col <= '0;
          r_emit_row  <= r_emit_row + 1'b1;
          r_emit_slot <= (r_emit_slot == SW'(P_KERNEL - 1)) ? '0 : r_emit_slot + 1'b1;
        end else begin
          r_sweep_col <= r_sweep_col + 1'b1;
        end
      end
    end
  end

  // Line storage is deliberately not reset; only rows written this frame are read.
  always_ff @(posedge I_CLK) begin
    if (!I_RESET && w_accept) begin
      r_mem[r_in_slot][r_in_col] <= I_PIXEL;
    end
  end

  for (genvar gi = 0; gi < LP_K; gi++) begin : g_tap_row
    for (genvar gj = 0; gj < LP_K; gj++) begin : g_tap_col
      localparam int LP_T = gi * LP_K + gj;
      logic [P_PIXEL_DEPTH-1:0] w_tap;

      always_comb begin : p_tap
        int            sr;
        int            sc;
        int            sl;
        logic          in_frame;
        logic [SW-1:0] slot;
        logic [CW-1:0] col;
        sr       = int'(r_emit_row) + gi - LP_H;
        sc       = int'(r_sweep_col) + gj - LP_H;
        in_frame = (sr >= 0) && (sr < LP_ROWS) && (sc >= 0) && (sc < LP_COLS);
        if (sr < 0) sr = 0;
        if (sr > LP_ROWS - 1) sr = LP_ROWS - 1;
        if (sc < 0) sc = 0;
        if (sc > LP_COLS - 1) sc = LP_COLS - 1;
        // Source row is within +-H of the centre, so one wrap step finds its slot.
        sl = int'(r_emit_slot) + (sr - int'(r_emit_row));
        if (sl < 0) sl = sl + LP_K;
        if (sl >= LP_K) sl = sl - LP_K;
        slot  = sl[SW-1:0];
        col   = sc[CW-1:0];
        w_tap = (in_frame || r_mode) ? r_mem[slot][col] : '0;
      end

      assign w_window[(LP_KK-1-LP_T)*LP_D +: LP_D] = w_tap;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_ready      <= 1'b1;
      r_valid      <= 1'b0;
      r_window     <= '0;
      r_center_col <= '0;
      r_center_row <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_ready      <= (w_state_next == StLoad);
      r_valid      <= w_sweeping;
      r_frame_done <= w_frame_last;
      if (w_sweeping) begin
        r_window     <= w_window;
        r_center_col <= r_sweep_col;
        r_center_row <= r_emit_row;
      end
    end
  end

  assign O_READY         = r_ready;
  assign O_VALID         = r_valid;
  assign O_WINDOW        = r_window;
  assign O_CENTER_COLUMN = r_center_col;
  assign O_CENTER_ROW    = r_center_row;
  assign O_FRAME_DONE    = r_frame_done;

endmodule
